reg_block_4x16: RTL and testbench
=================================

Name:
reg_block_4x16

Overview:
- Register file with four 16-bit general-purpose registers.
- One synchronous write port and two independent combinational read ports.
- Exports four per-register write-strobe signals, one per register.
- Sits in the processor datapath between instruction decode (register numbers) and the ALU/operand buses.

Parameters:
- WIDTH, 16, data width of each register and of the wd/rd ports.
- Register count is fixed at 4, addressed by 2 bits; it is not a parameter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low; clears all registers.
- rn_1  input  2  register number for read port 1.
- rn_2  input  2  register number for read port 2.
- wn  input  2  register number written by the write port.
- w  input  1  write enable, active-high.
- wd  input  WIDTH  write data.
- rd_1  output  WIDTH  contents of register rn_1.
- rd_2  output  WIDTH  contents of register rn_2.
- reg_1_store  output  1  write strobe for register 0 (wn==0).
- reg_2_store  output  1  write strobe for register 1 (wn==1).
- reg_3_store  output  1  write strobe for register 2 (wn==2).
- reg_4_store  output  1  write strobe for register 3 (wn==3).

Behaviour:
- Reset:
  - rst low asserts immediately, independent of clk, and sets all four registers to 0.
  - While rst is low, rd_1 and rd_2 read 0 and writes are ignored.
  - Release is synchronous-safe: the first write can occur on the first rising edge with rst high.
- Write decode:
  - reg_k_store = w AND (wn == k-1), purely combinational.
  - At most one strobe is high; all four are 0 when w=0.
  - Strobes are not gated by rst.
- Write: on the rising clk edge with rst high and w=1, register[wn] <= wd. Registers not selected hold their value.
- Read:
  - rd_1 = register[rn_1] and rd_2 = register[rn_2], combinational with zero cycle latency.
  - Both ports may address the same register at once.
- Read-during-write:
  - A read of register wn in the same cycle returns the old value.
  - The new value appears after the clock edge; there is no write-through bypass.
- Width: wn, rn_1 and rn_2 are exactly 2 bits, so no out-of-range address exists. wd is stored unmodified.
- Write latency is 1 clock edge.
- Reset mid-operation: an asynchronous clear overrides a write pending on the same edge.

Decomposition:
- Shared package holds WIDTH=16 and the register-index typedef (2-bit).
- Sub-module reg_cell (one WIDTH-bit register with clk, rst, store, in, out), instantiated four times.
- The 2-to-4 strobe decoder and the two 4-to-1 read muxes are written inline in the top module.

Test Plan:
- rst=0 with w=1, wn=2, wd=15 -> rd_1 (rn_1=0) = 0, rd_2 (rn_2=2) = 0 on every clk edge while rst is low; registers stay 0.
- Release rst, w=1, wn=2, wd=15 -> reg_3_store=1 and the other strobes 0; after the next rising edge rd_2 (rn_2=2) = 15 and rd_1 (rn_1=0) = 0.
- w=1, wn=0, wd=15 -> after the edge rd_1 (rn_1=0) = 15 and reg_1_store=1; register 2 still reads 15.
- wn=1, wd=100, rn_1=1, rn_2=3 -> rd_1 shows the old value 0 until the edge, then 100; rd_2 = 0.
- w=0 with rn_2=2 and wd changed to 55 -> all strobes 0; register contents remain 15/100/15/0 across several edges.
- Pulse rst low asynchronously between edges after writes -> rd_1 and rd_2 go to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/reg_block_4x16_pkg.sv
// Shared definitions for the 4x16 register file: data width and register index type.
package reg_block_4x16_pkg;

   localparam int WIDTH    = 16;
   localparam int NUM_REGS = 4;

   typedef logic [1:0] reg_idx_t;

endpackage

// File: rtl/reg_block_4x16_reg_cell.sv
// One register of the file: loads data_in on a rising edge when store is high,
// and is cleared asynchronously while rst (active-low) is low.
module reg_cell
   import reg_block_4x16_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         store,
   input  logic [W-1:0] data_in,
   output logic [W-1:0] data_out
);

   logic [W-1:0] value_d;
   logic [W-1:0] value_q;

   always_comb begin
      value_d = value_q;
      if (store) begin
         value_d = data_in;
      end
   end

   // The asynchronous clear wins over a load requested on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign data_out = value_q;

endmodule

// File: rtl/reg_block_4x16.sv
// Four-entry register file: one synchronous write port, two combinational read
// ports, and a per-register write strobe exported to the datapath.
module reg_block_4x16
   import reg_block_4x16_pkg::*;
#(
   parameter int WIDTH = reg_block_4x16_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       rn_1,
   input  logic [1:0]       rn_2,
   input  logic [1:0]       wn,
   input  logic             w,
   input  logic [WIDTH-1:0] wd,
   output logic [WIDTH-1:0] rd_1,
   output logic [WIDTH-1:0] rd_2,
   output logic             reg_1_store,
   output logic             reg_2_store,
   output logic             reg_3_store,
   output logic             reg_4_store
);

   logic [NUM_REGS-1:0] store;
   logic [WIDTH-1:0]    regs [NUM_REGS];
   reg_idx_t            wn_idx;
   reg_idx_t            rn_1_idx;
   reg_idx_t            rn_2_idx;

   assign wn_idx   = reg_idx_t'(wn);
   assign rn_1_idx = reg_idx_t'(rn_1);
   assign rn_2_idx = reg_idx_t'(rn_2);

   // Strobes are deliberately not gated by rst; the cells ignore them in reset.
   always_comb begin
      store = '0;
      if (w) begin
         store[wn_idx] = 1'b1;
      end
   end

   assign reg_1_store = store[0];
   assign reg_2_store = store[1];
   assign reg_3_store = store[2];
   assign reg_4_store = store[3];

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
      reg_cell #(
         .W (WIDTH)
      ) u_cell (
         .clk      (clk),
         .rst      (rst),
         .store    (store[g]),
         .data_in  (wd),
         .data_out (regs[g])
      );
   end

   // No write-through: a read of the register being written returns the old value.
   always_comb begin
      rd_1 = regs[rn_1_idx];
      rd_2 = regs[rn_2_idx];
   end

endmodule

// File: tb/tb_reg_block_4x16.sv
// Directed bench for reg_block_4x16: reset, write decode, reads, read-during-write
// and asynchronous clear, each scenario in its own task.
module tb_reg_block_4x16;

   localparam int W = 16;

   logic         clk;
   logic         rst;
   logic [1:0]   rn_1;
   logic [1:0]   rn_2;
   logic [1:0]   wn;
   logic         w;
   logic [W-1:0] wd;
   logic [W-1:0] rd_1;
   logic [W-1:0] rd_2;
   logic         reg_1_store;
   logic         reg_2_store;
   logic         reg_3_store;
   logic         reg_4_store;

   int tests_run;
   int tests_failed;

   reg_block_4x16 #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .rn_1        (rn_1),
      .rn_2        (rn_2),
      .wn          (wn),
      .w           (w),
      .wd          (wd),
      .rd_1        (rd_1),
      .rd_2        (rd_2),
      .reg_1_store (reg_1_store),
      .reg_2_store (reg_2_store),
      .reg_3_store (reg_3_store),
      .reg_4_store (reg_4_store)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] strobes();
      return {reg_4_store, reg_3_store, reg_2_store, reg_1_store};
   endfunction

   task automatic test_reset();
      rst  = 1'b0;
      w    = 1'b1;
      wn   = 2'd2;
      wd   = 16'd15;
      rn_1 = 2'd0;
      rn_2 = 2'd2;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         tests_run++;
         if (rd_1 !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_rd_1 edge %0d: got %0d expected 0", i, rd_1);
         end
         tests_run++;
         if (rd_2 !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_rd_2 edge %0d: got %0d expected 0", i, rd_2);
         end
      end
      tests_run++;
      if (strobes() !== 4'b0100) begin
         tests_failed++;
         $display("FAIL reset_strobe_ungated: got %b expected 0100", strobes());
      end
   endtask

   task automatic test_release_write();
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests_run++;
      if (strobes() !== 4'b0100) begin
         tests_failed++;
         $display("FAIL release_strobe: got %b expected 0100", strobes());
      end
      tests_run++;
      if (rd_2 !== 16'd0) begin
         tests_failed++;
         $display("FAIL release_pre_edge_rd_2: got %0d expected 0", rd_2);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (rd_2 !== 16'd15) begin
         tests_failed++;
         $display("FAIL release_write_rd_2: got %0d expected 15", rd_2);
      end
      tests_run++;
      if (rd_1 !== 16'd0) begin
         tests_failed++;
         $display("FAIL release_write_rd_1: got %0d expected 0", rd_1);
      end
   endtask

   task automatic test_write_r0();
      @(negedge clk);
      wn = 2'd0;
      wd = 16'd15;
      #1;
      tests_run++;
      if (strobes() !== 4'b0001) begin
         tests_failed++;
         $display("FAIL write_r0_strobe: got %b expected 0001", strobes());
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (rd_1 !== 16'd15) begin
         tests_failed++;
         $display("FAIL write_r0_rd_1: got %0d expected 15", rd_1);
      end
      tests_run++;
      if (rd_2 !== 16'd15) begin
         tests_failed++;
         $display("FAIL write_r0_r2_kept: got %0d expected 15", rd_2);
      end
   endtask

   task automatic test_read_during_write();
      @(negedge clk);
      wn   = 2'd1;
      wd   = 16'd100;
      rn_1 = 2'd1;
      rn_2 = 2'd3;
      #1;
      tests_run++;
      if (strobes() !== 4'b0010) begin
         tests_failed++;
         $display("FAIL rdw_strobe: got %b expected 0010", strobes());
      end
      tests_run++;
      if (rd_1 !== 16'd0) begin
         tests_failed++;
         $display("FAIL rdw_old_value: got %0d expected 0", rd_1);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (rd_1 !== 16'd100) begin
         tests_failed++;
         $display("FAIL rdw_new_value: got %0d expected 100", rd_1);
      end
      tests_run++;
      if (rd_2 !== 16'd0) begin
         tests_failed++;
         $display("FAIL rdw_rd_2: got %0d expected 0", rd_2);
      end
   endtask

   task automatic test_no_write();
      logic [W-1:0] exp_regs [4];
      exp_regs = '{16'd15, 16'd100, 16'd15, 16'd0};
      @(negedge clk);
      w    = 1'b0;
      wd   = 16'd55;
      rn_2 = 2'd2;
      #1;
      tests_run++;
      if (strobes() !== 4'b0000) begin
         tests_failed++;
         $display("FAIL no_write_strobe: got %b expected 0000", strobes());
      end
      repeat (3) @(posedge clk);
      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         wn   = r[1:0];
         rn_1 = r[1:0];
         rn_2 = 2'(3 - r);
         #1;
         tests_run++;
         if (rd_1 !== exp_regs[r]) begin
            tests_failed++;
            $display("FAIL no_write_rd_1 reg %0d: got %0d expected %0d", r, rd_1, exp_regs[r]);
         end
         tests_run++;
         if (rd_2 !== exp_regs[3-r]) begin
            tests_failed++;
            $display("FAIL no_write_rd_2 reg %0d: got %0d expected %0d", 3 - r, rd_2, exp_regs[3-r]);
         end
         tests_run++;
         if (strobes() !== 4'b0000) begin
            tests_failed++;
            $display("FAIL no_write_strobe wn %0d: got %b expected 0000", r, strobes());
         end
      end
   endtask

   task automatic test_full_scale_same_port();
      @(negedge clk);
      w    = 1'b1;
      wn   = 2'd3;
      wd   = 16'hFFFF;
      rn_1 = 2'd3;
      rn_2 = 2'd3;
      #1;
      tests_run++;
      if (strobes() !== 4'b1000) begin
         tests_failed++;
         $display("FAIL r3_strobe: got %b expected 1000", strobes());
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (rd_1 !== 16'hFFFF || rd_2 !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL same_reg_both_ports: got %h/%h expected ffff/ffff", rd_1, rd_2);
      end
      @(negedge clk);
      w = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      rn_1 = 2'd1;
      rn_2 = 2'd3;
      #2;
      rst = 1'b0;
      #1;
      tests_run++;
      if (rd_1 !== 16'd0 || rd_2 !== 16'd0) begin
         tests_failed++;
         $display("FAIL async_clear: got %0d/%0d expected 0/0", rd_1, rd_2);
      end
      // Write held across an edge during reset must be discarded.
      w  = 1'b1;
      wn = 2'd1;
      wd = 16'h1234;
      @(posedge clk);
      #1;
      tests_run++;
      if (rd_1 !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_overrides_write: got %h expected 0000", rd_1);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (rd_1 !== 16'h1234 || rd_2 !== 16'd0) begin
         tests_failed++;
         $display("FAIL post_reset_write: got %h/%h expected 1234/0000", rd_1, rd_2);
      end
      @(negedge clk);
      w = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst  = 1'b0;
      w    = 1'b0;
      wn   = 2'd0;
      wd   = '0;
      rn_1 = 2'd0;
      rn_2 = 2'd0;
      test_reset();
      test_release_write();
      test_write_r0();
      test_read_during_write();
      test_no_write();
      test_full_scale_same_port();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
